// File: rtl/minterm_sweep_ctrl.sv
// Sweeps all 16 {d,a,b,c} vectors into a downstream circuit and scores its e/f replies
// against the expected function e = ~c | (a & b), f = e & d.
module minterm_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       e,
    input  logic       f,
    output logic       busy,
    output logic       done,
    output logic [4:0] err_cnt,
    output logic [3:0] fail_idx,
    output logic       pass
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] vec_q, vec_d;       // {d,a,b,c}
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [4:0] err_q, err_d;
    logic [3:0] fidx_q, fidx_d;
    logic       pass_q, pass_d;

    logic e_exp, f_exp, mismatch;

    always_comb begin
        e_exp    = ~idx_q[0] | (idx_q[2] & idx_q[1]);
        f_exp    = e_exp & idx_q[3];
        mismatch = (e != e_exp) || (f != f_exp);

        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        fidx_d  = fidx_q;
        pass_d  = pass_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = 4'd0;
                    cnt_d   = 4'd0;
                    vec_d   = 4'd0;
                    busy_d  = 1'b1;
                    err_d   = 5'd0;
                    fidx_d  = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 5'd1;
                    if (err_q == 5'd0) fidx_d = idx_q;
                end
                if (idx_q == 4'd15) begin
                    // pass is resolved here so it is already valid alongside the done pulse
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 5'd0);
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 4'd1;
                    vec_d   = idx_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            vec_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 5'd0;
            fidx_q  <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            pass_q  <= pass_d;
        end
    end

    assign d        = vec_q[3];
    assign a        = vec_q[2];
    assign b        = vec_q[1];
    assign c        = vec_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_cnt  = err_q;
    assign fail_idx = fidx_q;
    assign pass     = pass_q;

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// Bench for minterm_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) driven by a
// selectable downstream response model, vector table plus reset/held-start sequences.
module tb_minterm_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start1, start3;
    logic a1, b1, c1, d1, e1, f1, busy1, done1, pass1;
    logic a3, b3, c3, d3, e3, f3, busy3, done3, pass3;
    logic [4:0] err1, err3;
    logic [3:0] fidx1, fidx3;

    int mode;
    bit sel;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    minterm_sweep_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1),
        .busy(busy1), .done(done1), .err_cnt(err1), .fail_idx(fidx1), .pass(pass1)
    );

    minterm_sweep_ctrl #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .a(a3), .b(b3), .c(c3), .d(d3), .e(e3), .f(f3),
        .busy(busy3), .done(done3), .err_cnt(err3), .fail_idx(fidx3), .pass(pass3)
    );

    // Downstream circuit: mode 0 correct, 1 f stuck 0, 2 e inverted,
    // 3 e stuck 1, 4 f stuck 1, 5 f ignores d
    function automatic logic [1:0] resp(input int m, input logic va, vb, vc, vd);
        logic eo, fo;
        eo = ~vc | (va & vb);
        fo = eo & vd;
        case (m)
            1:       return {eo, 1'b0};
            2:       return {~eo, fo};
            3:       return {1'b1, fo};
            4:       return {eo, 1'b1};
            5:       return {eo, eo};
            default: return {eo, fo};
        endcase
    endfunction

    always_comb {e1, f1} = resp(mode, a1, b1, c1, d1);
    always_comb {e3, f3} = resp(mode, a3, b3, c3, d3);

    logic [3:0] s_vec;
    logic       s_busy, s_done, s_pass;
    logic [4:0] s_err;
    logic [3:0] s_fidx;
    logic [15:0] s_all;

    always_comb begin
        s_vec  = sel ? {d3, a3, b3, c3} : {d1, a1, b1, c1};
        s_busy = sel ? busy3 : busy1;
        s_done = sel ? done3 : done1;
        s_err  = sel ? err3  : err1;
        s_fidx = sel ? fidx3 : fidx1;
        s_pass = sel ? pass3 : pass1;
        s_all  = {s_vec, s_busy, s_done, s_err, s_fidx, s_pass};
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulses (or holds) start, then follows the selected instance cycle by cycle.
    // Cycle k after the accepting edge must show vector k/(settle+1) with busy high.
    task automatic run_sweep(input int settle, input bit hold_start, output int lat);
        int tr_bad;
        tr_bad = 0;
        lat    = -1;
        @(negedge clk);
        if (sel) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) begin
            start1 = 1'b0;
            start3 = 1'b0;
        end
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_done) begin
                lat = k;
                break;
            end
            if (!s_busy || s_vec != 4'(k / (settle + 1))) tr_bad++;
            if (k == 0 && (s_err != 5'd0 || s_fidx != 4'd0 || s_pass)) tr_bad++;
        end
        chk("sweep_trace", tr_bad, 0);
        chk("done_latency", lat, 16 * (settle + 1));
        chk("busy_at_done", int'(s_busy), 0);
    endtask

    typedef struct {
        int mode;
        int settle;
        int exp_err;
        int exp_fidx;
        int exp_pass;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int lat;
        int seen_done;
        int found;

        tbl[0] = '{0, 1, 0,  0, 1};
        tbl[1] = '{1, 1, 5,  8, 0};
        tbl[2] = '{2, 1, 16, 0, 0};
        tbl[3] = '{3, 1, 6,  1, 0};
        tbl[4] = '{4, 1, 11, 0, 0};
        tbl[5] = '{5, 1, 5,  0, 0};
        tbl[6] = '{0, 3, 0,  0, 1};
        tbl[7] = '{2, 3, 16, 0, 0};

        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        mode   = 0;
        sel    = 1'b0;

        #2;
        chk("reset_state_s1", int'(s_all), 0);
        sel = 1'b1;
        #1;
        chk("reset_state_s3", int'(s_all), 0);
        sel = 1'b0;

        @(posedge clk);
        #3 rst_n = 1'b1;

        foreach (tbl[i]) begin
            mode = tbl[i].mode;
            sel  = (tbl[i].settle == 3);
            run_sweep(tbl[i].settle, 1'b0, lat);
            chk($sformatf("err_cnt[%0d]", i), int'(s_err), tbl[i].exp_err);
            chk($sformatf("fail_idx[%0d]", i), int'(s_fidx), tbl[i].exp_fidx);
            chk($sformatf("pass[%0d]", i), int'(s_pass), tbl[i].exp_pass);
            @(negedge clk);
            chk($sformatf("idle_hold[%0d]", i),
                int'({s_busy, s_done, s_vec, s_err, s_fidx, s_pass}),
                int'({1'b0, 1'b0, 4'hF, 5'(tbl[i].exp_err), 4'(tbl[i].exp_fidx), 1'(tbl[i].exp_pass)}));
        end

        // Asynchronous reset while vector 5 is on the bus
        sel  = 1'b0;
        mode = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("vec5_before_reset", int'(s_vec), 5);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(s_all), 0);
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (s_done || s_busy) seen_done++;
        end
        chk("no_done_in_reset", seen_done, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        run_sweep(1, 1'b0, lat);
        chk("resweep_err", int'(s_err), 0);
        chk("resweep_pass", int'(s_pass), 1);

        // start held high across a whole sweep
        run_sweep(1, 1'b1, lat);
        chk("held_err", int'(s_err), 0);
        @(negedge clk);
        chk("held_idle_gap", int'(s_busy), 0);
        @(negedge clk);
        chk("held_restart", int'({s_busy, s_vec}), int'({1'b1, 4'h0}));
        start1 = 1'b0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_done) begin
                found = 1;
                break;
            end
        end
        chk("held_second_done", found, 1);
        chk("held_second_pass", int'(s_pass), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
